// File: rtl/fix_stream_parser.sv
// FIX byte-stream parser: splits "tag=value<SOH>" fields, emits them one at a
// time through a valid/ready register, and checks the trailing "10=nnn" sum.
module fix_stream_parser #(
  parameter int TAG_WIDTH   = 20,
  parameter int TAG_DIGITS  = 5,
  parameter int VALUE_BYTES = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [7:0]                   in_data,
  output logic                         in_ready,
  output logic                         field_valid,
  input  logic                         field_ready,
  output logic [TAG_WIDTH-1:0]         field_tag,
  output logic [8*VALUE_BYTES-1:0]     field_value,
  output logic [$clog2(VALUE_BYTES+1)-1:0] field_len,
  output logic                         msg_done,
  output logic                         msg_ok,
  output logic                         msg_err,
  output logic [2:0]                   err_code
);

  localparam int LW = $clog2(VALUE_BYTES + 1);
  localparam int DW = $clog2(TAG_DIGITS + 2);

  typedef enum logic [2:0] {IDLE, TAG, VALUE, CKSUM, RESYNC} state_t;

  state_t                     state, state_next;
  logic                       accept, is_digit, is_soh, is_eq;
  logic [TAG_WIDTH-1:0]       tag;
  logic [TAG_WIDTH+3:0]       tag_wide;
  logic [DW-1:0]              digits;
  logic [LW-1:0]              len;
  logic                       first;
  logic [7:0]                 sum, sum_mark;
  logic [8*VALUE_BYTES-1:0]   value_buf;
  logic [9:0]                 ck_value;
  logic                       do_start, do_digit, do_value, do_cksum;
  logic                       do_store, do_field, do_done, do_err;
  logic [2:0]                 err_next;

  // A new byte can only be taken once the output field slot is free or being freed.
  assign in_ready = !field_valid || field_ready;
  assign accept   = in_valid && in_ready;
  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_soh   = (in_data == 8'h01);
  assign is_eq    = (in_data == 8'h3D);
  assign tag_wide = {4'b0000, tag} * (TAG_WIDTH+4)'(10) + (TAG_WIDTH+4)'(in_data[3:0]);
  // Checksum digits sit in value bytes 0..2, most significant first.
  assign ck_value = 10'(value_buf[3:0]) * 10'd100 + 10'(value_buf[11:8]) * 10'd10
                  + 10'(value_buf[19:16]);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Decode the accepted byte into a next state and a single datapath action.
  always_comb begin
    state_next = state;
    do_start = 1'b0; do_digit = 1'b0; do_value = 1'b0; do_cksum = 1'b0;
    do_store = 1'b0; do_field = 1'b0; do_done  = 1'b0; do_err   = 1'b0;
    err_next = 3'd0;
    if (accept) begin
      case (state)
        IDLE: if (in_data == 8'h38) begin do_start = 1'b1; state_next = TAG; end
        TAG: begin
          if (is_digit) begin
            if (digits == DW'(TAG_DIGITS)) begin do_err = 1'b1; err_next = 3'd3; end
            else do_digit = 1'b1;
          end else if (is_eq) begin
            if (digits == '0) begin do_err = 1'b1; err_next = 3'd2; end
            else if (tag == TAG_WIDTH'(10) && !first) begin do_cksum = 1'b1; state_next = CKSUM; end
            else begin do_value = 1'b1; state_next = VALUE; end
          end else begin
            do_err = 1'b1; err_next = 3'd1;
          end
        end
        VALUE: begin
          if (is_soh) begin do_field = 1'b1; state_next = TAG; end
          else if (len == LW'(VALUE_BYTES)) begin do_err = 1'b1; err_next = 3'd4; end
          else do_store = 1'b1;
        end
        CKSUM: begin
          if (is_soh) begin
            if (len == LW'(3)) begin do_done = 1'b1; state_next = IDLE; end
            else begin do_err = 1'b1; err_next = 3'd5; end
          end else if (is_digit && len != LW'(3)) do_store = 1'b1;
          else begin do_err = 1'b1; err_next = 3'd5; end
        end
        RESYNC: if (is_soh) state_next = IDLE;
        default: state_next = IDLE;
      endcase
      if (do_err) state_next = RESYNC;
    end
  end

  // Datapath: tag/value accumulation, running sum, output field and pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag <= '0; digits <= '0; len <= '0; first <= 1'b0;
      sum <= '0; sum_mark <= '0; value_buf <= '0;
      field_valid <= 1'b0; field_tag <= '0; field_value <= '0; field_len <= '0;
      msg_done <= 1'b0; msg_ok <= 1'b0; msg_err <= 1'b0; err_code <= 3'd0;
    end else begin
      msg_done <= 1'b0;
      msg_ok   <= 1'b0;
      msg_err  <= 1'b0;
      if (field_valid && field_ready) field_valid <= 1'b0;
      if (do_start) begin
        sum <= in_data; tag <= TAG_WIDTH'(in_data[3:0]); digits <= DW'(1); first <= 1'b1;
      end
      if (do_digit) begin
        tag <= tag_wide[TAG_WIDTH-1:0]; digits <= digits + DW'(1); sum <= sum + in_data;
      end
      if (do_value) begin
        value_buf <= '0; len <= '0; sum <= sum + in_data;
      end
      if (do_cksum) begin
        value_buf <= '0; len <= '0; sum <= sum_mark;
      end
      if (do_store) begin
        for (int i = 0; i < VALUE_BYTES; i++)
          if (LW'(i) == len) value_buf[8*i +: 8] <= in_data;
        len <= len + LW'(1);
        if (state == VALUE) sum <= sum + in_data;
      end
      if (do_field) begin
        field_tag <= tag; field_value <= value_buf; field_len <= len; field_valid <= 1'b1;
        tag <= '0; digits <= '0; first <= 1'b0;
        sum <= sum + in_data; sum_mark <= sum + in_data;
      end
      if (do_done) begin
        field_tag <= TAG_WIDTH'(10); field_value <= value_buf; field_len <= LW'(3);
        field_valid <= 1'b1; msg_done <= 1'b1; msg_ok <= (ck_value == {2'b00, sum});
      end
      if (do_err) begin
        msg_err <= 1'b1; err_code <= err_next;
      end
    end
  end

endmodule

// File: tb/tb_fix_stream_parser.sv
// Randomised bench for fix_stream_parser: messages are generated from field
// lists, so the expected fields, checksums and error codes are known up front.
module tb_fix_stream_parser;

  localparam int TW = 20;
  localparam int VB = 32;
  localparam int LW = $clog2(VB + 1);

  logic          clk = 1'b0, rst = 1'b1;
  logic          in_valid = 1'b0, in_ready;
  logic [7:0]    in_data = 8'h00;
  logic          field_valid, field_ready = 1'b1;
  logic [TW-1:0] field_tag;
  logic [8*VB-1:0] field_value;
  logic [LW-1:0] field_len;
  logic          msg_done, msg_ok, msg_err;
  logic [2:0]    err_code;

  fix_stream_parser #(.TAG_WIDTH(TW), .TAG_DIGITS(5), .VALUE_BYTES(VB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .field_valid(field_valid), .field_ready(field_ready), .field_tag(field_tag),
    .field_value(field_value), .field_len(field_len), .msg_done(msg_done),
    .msg_ok(msg_ok), .msg_err(msg_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int ready_mode = 0;
  logic [7:0] tx[$];
  int exp_tag[$];
  logic [255:0] exp_val[$];
  int exp_len[$];
  int ev_type[$];
  int ev_arg[$];
  int last_ok = -1, last_code = -1, done_cnt = 0, err_cnt = 0;
  int sent_done = 0;
  logic held = 1'b0;
  logic [TW-1:0] h_tag;
  logic [255:0] h_val;
  logic [LW-1:0] h_len;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // downstream readiness: always, random, or held low
  initial forever begin
    @(negedge clk);
    field_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom % 2) : 1'b0;
  end

  // compare process, sampled just before each rising edge
  initial forever begin
    @(negedge clk); #3;
    if (rst) begin
      held = 1'b0;
    end else begin
      checkOutput("in_ready", in_ready, !field_valid || field_ready);
      if (held) begin
        checkOutput("hold_valid", field_valid, 1);
        if (field_valid) begin
          checkOutput("hold_tag", field_tag, h_tag);
          checkOutput("hold_val", field_value, h_val);
          checkOutput("hold_len", field_len, h_len);
        end
      end
      if (field_valid && field_ready) begin
        held = 1'b0;
        if (exp_tag.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL extra_field: got tag %0d expected none", field_tag);
        end else begin
          checkOutput("field_tag", field_tag, exp_tag.pop_front());
          checkOutput("field_value", field_value, exp_val.pop_front());
          checkOutput("field_len", field_len, exp_len.pop_front());
        end
      end else if (field_valid) begin
        held = 1'b1; h_tag = field_tag; h_val = field_value; h_len = field_len;
      end else begin
        held = 1'b0;
      end
      if (msg_done && msg_err) begin
        total++; bad++;
        $display("[TB] FAIL done_and_err: got both expected one");
      end
      if (msg_done || msg_err) begin
        if (ev_type.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL extra_event: got done=%0d err=%0d expected none", msg_done, msg_err);
        end else begin
          int t, a;
          t = ev_type.pop_front(); a = ev_arg.pop_front();
          checkOutput("event_kind", msg_err, t);
          if (msg_done) begin
            checkOutput("msg_ok", msg_ok, a); last_ok = int'(msg_ok); done_cnt++;
          end else begin
            checkOutput("err_code", err_code, a); last_code = int'(err_code); err_cnt++;
          end
        end
      end
    end
  end

  // drive one byte, with occasional idle cycles carrying junk data
  task automatic applyStimulus(input logic [7:0] b);
    int n;
    if ($urandom % 4 == 0) begin
      @(negedge clk); in_valid = 1'b0; in_data = 8'($urandom);
    end
    @(negedge clk); in_valid = 1'b1; in_data = b; #1;
    n = 0;
    while (!in_ready) begin
      @(negedge clk); #1; n++;
      if (n > 1000) begin
        total++; bad++;
        $display("[TB] FAIL accept_timeout: got in_ready=0 expected 1");
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic sendTx();
    foreach (tx[i]) applyStimulus(tx[i]);
    @(negedge clk); in_valid = 1'b0;
    tx.delete();
  endtask

  task automatic addStr(input string s);
    for (int i = 0; i < s.len(); i++)
      tx.push_back((s[i] == 8'h7C) ? 8'h01 : s[i]);
  endtask

  task automatic expectField(input int t, input logic [255:0] v, input int l);
    exp_tag.push_back(t); exp_val.push_back(v); exp_len.push_back(l);
  endtask

  function automatic logic [7:0] sumRange(input int from, input int to);
    logic [7:0] s = 8'h00;
    for (int i = from; i <= to; i++) s = s + tx[i];
    return s;
  endfunction

  task automatic pushField(input int t, input int l);
    logic [255:0] v = '0;
    addStr($sformatf("%0d=", t));
    for (int i = 0; i < l; i++) begin
      v[8*i +: 8] = 8'($urandom_range(32, 126));
      tx.push_back(v[8*i +: 8]);
    end
    tx.push_back(8'h01);
    expectField(t, v, l);
  endtask

  // kind 0 good sum, 1 wrong sum, 2..6 format error with code kind-1
  task automatic genMsg(input int kind, input int first_len);
    int start, t, ck;
    logic [7:0] s;
    string cs;
    logic [255:0] v;
    repeat ($urandom % 3) tx.push_back(8'(8'h41 + $urandom % 26));
    start = tx.size();
    pushField(8, (first_len < 0) ? $urandom_range(0, 12) : first_len);
    repeat ($urandom_range(0, 2)) begin
      t = $urandom_range(1, 99999);
      if (t == 10) t = 11;
      pushField(t, $urandom_range(0, VB));
    end
    if (kind <= 1) begin
      s = sumRange(start, tx.size() - 1);
      ck = (kind == 0) ? int'(s) : (int'(s) + $urandom_range(1, 700)) % 1000;
      cs = $sformatf("%03d", ck);
      addStr({"10=", cs, "|"});
      v = '0;
      for (int i = 0; i < 3; i++) v[8*i +: 8] = cs[i];
      expectField(10, v, 3);
      ev_type.push_back(0); ev_arg.push_back((ck == int'(s)) ? 1 : 0);
    end else begin
      case (kind - 1)
        1: addStr("3X=1|");
        2: addStr("=x|");
        3: addStr("123456=v|");
        4: begin
          addStr("55=");
          repeat (33) tx.push_back(8'($urandom_range(32, 126)));
          tx.push_back(8'h01);
        end
        default: case ($urandom % 3)
          0: addStr("10=1234|");
          1: addStr("10=1a3|");
          default: addStr("10=12||");
        endcase
      endcase
      ev_type.push_back(1); ev_arg.push_back(kind - 1);
    end
  endtask

  task automatic literalGood();
    addStr("8=A|10=183|");
    expectField(8, 256'h41, 1);
    expectField(10, 256'h333831, 3);
    ev_type.push_back(0); ev_arg.push_back(1);
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((exp_tag.size() > 0 || ev_type.size() > 0) && n < 3000) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    checkOutput("drain_fields", exp_tag.size(), 0);
    checkOutput("drain_events", ev_type.size(), 0);
  endtask

  initial begin
    int n, errs_before, r;
    repeat (3) @(negedge clk);
    checkOutput("rst_field_valid", field_valid, 0);
    checkOutput("rst_msg", {msg_done, msg_ok, msg_err}, 0);
    checkOutput("rst_err_code", err_code, 0);
    checkOutput("rst_field_len", field_len, 0);
    rst = 1'b0;

    addStr("8=A|");
    checkOutput("model_sum", sumRange(0, 3), 183);
    tx.delete();

    literalGood(); sendTx(); waitDrain();
    checkOutput("good_ok", last_ok, 1);

    errs_before = err_cnt;
    addStr("8=A|10=184|");
    expectField(8, 256'h41, 1);
    expectField(10, 256'h343831, 3);
    ev_type.push_back(0); ev_arg.push_back(0);
    sendTx(); waitDrain();
    checkOutput("badsum_ok", last_ok, 0);
    checkOutput("badsum_no_err", err_cnt, errs_before);

    addStr("8=A|3X=1|");
    expectField(8, 256'h41, 1);
    ev_type.push_back(1); ev_arg.push_back(1);
    literalGood(); sendTx(); waitDrain();
    checkOutput("err1_code", last_code, 1);
    checkOutput("after_err_ok", last_ok, 1);

    genMsg(0, 32); sendTx(); waitDrain();
    genMsg(5, -1); sendTx(); waitDrain();
    checkOutput("err4_code", last_code, 4);

    // downstream stalled for ten cycles after the first field
    ready_mode = 2;
    literalGood();
    fork begin sendTx(); sent_done = 1; end join_none
    n = 0;
    while (!field_valid && n < 200) begin @(negedge clk); n++; end
    checkOutput("stall_seen", field_valid, 1);
    repeat (10) begin
      @(negedge clk); #3;
      checkOutput("stall_in_ready", in_ready, 0);
    end
    ready_mode = 0;
    n = 0;
    while (sent_done == 0 && n < 500) begin @(negedge clk); n++; end
    waitDrain();
    checkOutput("stall_ok", last_ok, 1);

    for (int m = 0; m < 40; m++) begin
      ready_mode = $urandom % 2;
      r = $urandom % 20;
      genMsg((r < 11) ? 0 : (r < 14) ? 1 : 2 + $urandom % 5, -1);
      sendTx();
    end
    ready_mode = 0;
    waitDrain();

    // reset in the middle of a value
    addStr("8=AB"); sendTx();
    repeat (2) @(negedge clk);
    rst = 1'b1; #1;
    checkOutput("mid_rst_valid", field_valid, 0);
    checkOutput("mid_rst_msg", {msg_done, msg_ok, msg_err}, 0);
    checkOutput("mid_rst_tag", field_tag, 0);
    checkOutput("mid_rst_value", field_value, 0);
    checkOutput("mid_rst_len", field_len, 0);
    checkOutput("mid_rst_code", err_code, 0);
    @(negedge clk); rst = 1'b0;
    last_ok = -1;
    literalGood(); sendTx(); waitDrain();
    checkOutput("post_rst_ok", last_ok, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
